// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial subtractor controller, LSB-first, one bit per clock
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.

module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             br_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             br_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             bor;
    logic             sbit;
    logic             sbr;

    full_sub u_full_sub (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (bor),
        .d    (sbit),
        .bout (sbr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            br_out <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            bor    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // DONE accepts start exactly like IDLE so ops can run back-to-back
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        bor   <= br_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res_sr <= (WIDTH-1)'({sbit, res_sr} >> 1);
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    bor    <= sbr;
                    if (cnt == LAST) begin
                        diff   <= {sbit, res_sr};
                        br_out <= sbr;
`ifdef SERIAL_SUB_OVF_EN
                        // bor is the borrow into the MSB at this edge
                        ovf    <= bor ^ sbr;
`endif
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
